// File: rtl/bit8_add_if.sv
// rtl/bit8_add_if.sv - operand/result bundle for the registered ripple-carry adder
// master drives operands and samples results; slave is the adder side.
interface bit8_add_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/bit8_add.sv
// rtl/bit8_add.sv - registered ripple-carry adder built from 1-bit full-adder cells
// One-cycle latency, one operation per cycle; results hold while in_valid is low.
module bit8_add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module bit8_add #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  bit8_add_if.slave    bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bit8_add_fa u_fa (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .c_i (carry[i]),
      .s_o (s[i]),
      .c_o (carry[i+1])
    );
  end

  // Idle cycles keep the last result visible but mark it stale.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d       = {carry[WIDTH], s};
      cout_d      = carry[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bit8_add.sv
// tb/tb_bit8_add.sv - scoreboard bench for bit8_add
// Expected sums are queued at drive time and retired one edge later.
module tb_bit8_add;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bit8_add_if #(.WIDTH(W)) bus ();

  bit8_add #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [W:0] exp_q[$];
  logic [W:0] held;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives operands, waits one edge, checks the result.
  task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
    if (v) exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c});
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, v});
    if (v) held = exp_q.pop_front();
    check_eq("sum", {23'd0, bus.sum}, {23'd0, held});
    check_eq("cout", {31'd0, bus.cout}, {31'd0, held[W]});
    check_eq("cout_eq_msb", {31'd0, bus.cout}, {31'd0, bus.sum[W]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    held         = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.cin      = 1'b1;
    #1;
    check_eq("rst_sum", {23'd0, bus.sum}, 32'h0);
    check_eq("rst_cout", {31'd0, bus.cout}, 32'h0);
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_sum", {23'd0, bus.sum}, 32'h0);
    check_eq("rst_hold_valid", {31'd0, bus.out_valid}, 32'h0);
    rst = 1'b0;

    step(1'b1, 8'h00, 8'h00, 1'b0);
    check_eq("zero", {23'd0, bus.sum}, 32'h000);
    step(1'b1, 8'hFF, 8'hFF, 1'b0);
    check_eq("max_nocin", {23'd0, bus.sum}, 32'h1FE);
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    check_eq("max_cin", {23'd0, bus.sum}, 32'h1FF);
    step(1'b1, 8'hAA, 8'h55, 1'b1);
    check_eq("ripple_cin", {23'd0, bus.sum}, 32'h100);
    step(1'b1, 8'hAA, 8'h55, 1'b0);
    check_eq("ripple_nocin", {23'd0, bus.sum}, 32'h0FF);
    step(1'b1, 8'h12, 8'h34, 1'b0);
    check_eq("simple", {23'd0, bus.sum}, 32'h046);
    step(1'b0, 8'h77, 8'h88, 1'b1);
    check_eq("hold_sum", {23'd0, bus.sum}, 32'h046);

    // Present a valid op, then reset between edges: result clears, op is dropped.
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    bus.cin      = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_sum", {23'd0, bus.sum}, 32'h0);
    check_eq("async_rst_cout", {31'd0, bus.cout}, 32'h0);
    check_eq("async_rst_valid", {31'd0, bus.out_valid}, 32'h0);
    held = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("rst_inflight_sum", {23'd0, bus.sum}, 32'h0);
    check_eq("rst_inflight_valid", {31'd0, bus.out_valid}, 32'h0);
    rst = 1'b0;

    step(1'b0, 8'h5A, 8'hA5, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit8_add.md
Name: bit8_add

Overview:
- Registered ripple-carry adder: adds two WIDTH-bit operands plus a carry-in and registers a WIDTH+1-bit sum and a carry-out.
- Default width is 8 bits.
- Used as the arithmetic datapath leaf in the full-adder subsystem. It is built from a chain of 1-bit full-adder cells and feeds downstream logic through registered outputs.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH+1  registered result a+b+cin; bit WIDTH is the final carry.
- cout  output  1  registered carry-out of bit WIDTH-1; always equal to sum[WIDTH].
- out_valid  output  1  sum/cout hold the result of a valid operation.

Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Datapath:
  - Combinational ripple-carry chain of WIDTH full-adder cells.
  - Cell i: s_i = a[i]^b[i]^c_i; c_{i+1} = a[i]&b[i] | c_i&(a[i]^b[i]); c_0 = cin.
  - The result is {c_WIDTH, s_{WIDTH-1..0}}, which equals the exact unsigned value a+b+cin.
  - Maximum value is 2^(WIDTH+1)-1 (0x1FF for WIDTH=8). No overflow is possible in sum.
- Timing:
  - Latency is 1 clock: on a rising clk edge with in_valid=1, sum <= result, cout <= c_WIDTH, out_valid <= 1.
  - Throughput is one operation per cycle; new operands may change every cycle.
- Idle:
  - On a rising edge with in_valid=0, sum and cout hold their previous values and out_valid <= 0.
- Reset:
  - rst=1 immediately (asynchronously) forces sum=0, cout=0, out_valid=0, and they stay there while rst is high.
  - Reset mid-stream discards the in-flight result.
  - The first capture after deassertion occurs at the first rising edge with rst=0 and in_valid=1.
- Invariant: cout == sum[WIDTH] at all times, including during reset.
- Signedness: no internal signed interpretation; operands and result are unsigned.
- No X propagation from unused state: every register is reset.

Test Plan:
- Reset: assert rst with a=0xFF, b=0xFF, cin=1 present -> sum=0x000, cout=0, out_valid=0 immediately and while held.
- Zero: a=0x00, b=0x00, cin=0, in_valid=1 -> next edge sum=0x000, cout=0, out_valid=1.
- Max carry: a=0xFF, b=0xFF, cin=0 -> sum=0x1FE, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0x1FF, cout=1.
- Full ripple: a=0xAA, b=0x55, cin=1 -> sum=0x100, cout=1, with the carry propagating through all 8 cells. a=0xAA, b=0x55, cin=0 -> sum=0x0FF, cout=0.
- Hold/valid:
  - Issue a=0x12, b=0x34, cin=0 -> sum=0x046.
  - Drop in_valid and change the operands -> sum stays 0x046, out_valid=0.
  - Assert rst between edges -> sum clears to 0 without a clock edge.
- Random: 1000 back-to-back random (a, b, cin) with random in_valid -> every captured sum equals the reference a+b+cin one cycle later, and cout==sum[8] always.
